// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and constants for the pc sequencer
//
// Purpose: state encoding and address increment shared by the pc sequencer files.
// Ports:   none (package).
package pc_pkg;

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
    localparam logic [1:0]  ST_HALT = 2'd2;

    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between datapath and pc sequencer
//
// Purpose: groups the datapath-side control inputs and the sequencer status outputs.
// Ports (signals):
//   start, stall, branch_taken, branch_imm[15:0], jump, jump_target[25:0], halt_req
//       driven by the datapath/bench (master), sampled by the sequencer (slave).
//   pc[31:0], pc_valid, halted, timeout, cycle_count, instr_count
//       driven by the sequencer (slave).
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             branch_taken;
    logic [15:0]      branch_imm;
    logic             jump;
    logic [25:0]      jump_target;
    logic             halt_req;

    logic [31:0]      pc;
    logic             pc_valid;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, stall, branch_taken, branch_imm, jump, jump_target, halt_req,
        input  pc, pc_valid, halted, timeout, cycle_count, instr_count
    );

    modport slave (
        input  start, stall, branch_taken, branch_imm, jump, jump_target, halt_req,
        output pc, pc_valid, halted, timeout, cycle_count, instr_count
    );

endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// rtl/pc_sequencer_next_pc_calc.sv - combinational next-pc priority mux
//
// Purpose: computes pc+4, branch target, jump target and selects the next pc.
// Ports:
//   pc_i[31:0]          current pc
//   stall_i             hold pc (highest priority)
//   jump_i              take jump_target_i
//   jump_target_i[25:0] instruction[25:0]
//   branch_taken_i      take branch
//   branch_imm_i[15:0]  signed word offset relative to pc+4
//   next_pc_o[31:0]     selected next pc
module next_pc_calc
    import pc_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;

    assign pc_plus4  = pc_i + PC_INC;
    // Word offset sign-extended and scaled to bytes; wraps modulo 2^32.
    assign branch_pc = pc_plus4 + {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
    // Jump stays inside the 256 MB region selected by pc+4.
    assign jump_pc   = {pc_plus4[31:28], jump_target_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4;
        if (stall_i) begin
            next_pc_o = pc_i;
        end else if (jump_i) begin
            next_pc_o = jump_pc;
        end else if (branch_taken_i) begin
            next_pc_o = branch_pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter stage with run/halt FSM and counters
//
// Purpose: owns the pc register feeding the datapath, sequences IDLE/RUN/HALT,
//          counts RUN cycles and retired instructions, and flags MAX_INSTR timeouts.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   pc_sequencer_if.slave: control inputs in, pc/status/counters out
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] END_PC    = 32'h0000_0100,
    parameter int          MAX_INSTR = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.slave   bus
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instr_q, instr_d;
    logic               timeout_q, timeout_d;

    logic [31:0]        next_pc;
    logic               hit_end;
    logic               hit_max;

    next_pc_calc u_next_pc_calc (
        .pc_i           (pc_q),
        .stall_i        (bus.stall),
        .jump_i         (bus.jump),
        .jump_target_i  (bus.jump_target),
        .branch_taken_i (bus.branch_taken),
        .branch_imm_i   (bus.branch_imm),
        .next_pc_o      (next_pc)
    );

    assign hit_end = (next_pc == END_PC);
    // Compared at 32 bits so a MAX_INSTR wider than the counter never aliases.
    assign hit_max = ((32'(instr_q) + 32'd1) == 32'(MAX_INSTR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            cycle_q   <= '0;
            instr_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    pc_d      = RESET_PC;
                    cycle_d   = '0;
                    instr_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
                // A stalled cycle neither retires nor evaluates any halt cause.
                if (!bus.stall) begin
                    if (instr_q != '1) begin
                        instr_d = instr_q + CNT_W'(1);
                    end
                    if (bus.halt_req || hit_end || hit_max) begin
                        // pc stays on the last fetched address while halted.
                        state_d   = S_HALT;
                        timeout_d = timeout_q | hit_max;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = (state_q == S_RUN);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_q;
    assign bus.instr_count = instr_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly upstream of the single-cycle datapath; owns the 32-bit pc register that drives the datapath's pc input every cycle.
- Sequential next-pc selection: +4, branch or jump, with stall, halt and timeout control.
- Counts cycles and retired instructions for the matrix-program bench.
- Asserts halted once the program ends, so the bench can sample the d11..d33 results.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset and on start.
- END_PC, 32'h0000_0100, byte address one past the last instruction; reaching it halts.
- MAX_INSTR, 1024, retired-instruction limit; reaching it halts with timeout flag.
- CNT_W, 16, width of the cycle and instruction counters.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; IDLE/HALT -> RUN, pc <= RESET_PC.
- stall, input, 1, hold pc this cycle; no retire.
- branch_taken, input, 1, current instruction is a taken conditional branch.
- branch_imm, input, 16, instruction[15:0] branch offset in words.
- jump, input, 1, current instruction is a jump.
- jump_target, input, 26, instruction[25:0].
- halt_req, input, 1, halt opcode decoded; retire it, then stop.
- pc, output, 32, byte address fed to the datapath.
- pc_valid, output, 1, high in RUN; datapath write enables gate on it.
- halted, output, 1, high in HALT.
- timeout, output, 1, sticky; halt was caused by MAX_INSTR.
- cycle_count, output, CNT_W, clk edges spent in RUN.
- instr_count, output, CNT_W, instructions retired.

Behaviour:
- Reset (rst sampled high at a clk edge, any state, mid-run included):
  - state <= IDLE, pc <= RESET_PC.
  - pc_valid, halted and timeout all 0.
  - Both counters 0.
  - All other inputs are ignored in that cycle.
- States:
  - IDLE: pc_valid=0. On start -> RUN, pc <= RESET_PC, counters cleared, timeout cleared.
  - RUN: pc_valid=1; one instruction per cycle unless stalled.
  - HALT: pc_valid=0, halted=1, pc frozen at the last fetched address. start restarts exactly as in IDLE.
- Next-pc in RUN, priority high to low:
  1. stall: pc holds, instr_count holds, cycle_count increments. Stall also masks halt_req, jump and branch in that cycle.
  2. jump: pc <= {pc_plus4[31:28], jump_target, 2'b00}.
  3. branch_taken: pc <= pc_plus4 + ({{14{branch_imm[15]}}, branch_imm, 2'b00}).
  4. Otherwise: pc <= pc_plus4.
- pc_plus4 = pc + 4. All address arithmetic is modulo 2^32; wrap-around is silent.
- Retire: every non-stalled RUN cycle increments instr_count by 1, saturating at all-ones.
- cycle_count increments on every RUN cycle, saturating at all-ones.
- Halt conditions, evaluated on non-stalled RUN cycles; the current instruction retires in all three cases:
  - halt_req=1: -> HALT, pc holds.
  - Computed next pc == END_PC: -> HALT, pc holds (does not advance to END_PC).
  - instr_count+1 == MAX_INSTR: -> HALT, timeout <= 1.
  - Several conditions in one cycle: single HALT transition. timeout is set only if the MAX_INSTR condition is among them.
- Latency:
  - pc changes one clk after the control inputs are sampled.
  - Control inputs are combinational from the datapath for the current pc; the sequencer registers nothing else.
- start while in RUN is ignored.

Decomposition:
- Shared package pc_pkg:
  - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2.
  - PC_INC=32'd4.
- Sub-module next_pc_calc: purely combinational; computes pc_plus4, the branch target, the jump target and the priority mux output.
- pc_sequencer holds the FSM, the pc register, the counters and the halt logic.

Test Plan:
- Reset then start, no control for 3 cycles:
  - pc = 0x0, 0x4, 0x8, 0xC.
  - instr_count = 3, cycle_count = 3, pc_valid = 1.
- At pc=0x10, branch_taken=1 with branch_imm=16'hFFFE:
  - next pc = 0x0C.
  - Then stall held 2 cycles: pc stays 0x0C, instr_count unchanged, cycle_count +2.
- At pc=0xF0000004, jump=1 with jump_target=26'h0000010:
  - pc = 0xF0000040.
  - Also assert branch_taken in the same cycle: the jump still wins.
- END_PC=0x20, run straight from 0x0:
  - halted rises after the instruction at 0x1C retires, with pc frozen at 0x1C.
  - instr_count = 8, timeout = 0, pc_valid = 0.
- MAX_INSTR=5, branch loop with branch_imm=16'hFFFF at pc=0x8:
  - halt after the 5th retire, timeout = 1.
  - Then start: pc = 0x0, counters 0, timeout = 0.
- rst asserted mid-RUN together with jump=1:
  - next cycle pc = RESET_PC, state IDLE, all outputs at their reset values.
  - halt_req together with stall=1: no halt until the cycle stall drops.
